// File: rtl/ft_recovery_unit_pkg.sv
// Shared types and defaults for the fault-tolerance recovery responder.
// The VERIFY state and retry limit are only used when FT_RECOVERY_VERIFY_EN is defined.
package ft_recovery_unit_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;
  localparam int RETRY_LIMIT  = 2;

  typedef enum logic [2:0] {
    IDLE,
    COPY,
    PC,
    DONE,
    VERIFY
  } state_t;

endpackage

// File: rtl/ft_recovery_unit_if.sv
// Bundle between the ft controller, the golden regfile read port and the target cores.
// FT_RECOVERY_VERIFY_EN adds the target readback data and the verify failure flag.
interface ft_recovery_unit_if
  import ft_recovery_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              recover_i;
  logic              recovering_i;
  logic [ADDR_W-1:0] rf_raddr_o;
  logic [DATA_W-1:0] rf_rdata_i;
  logic              rf_we_o;
  logic [ADDR_W-1:0] rf_waddr_o;
  logic [DATA_W-1:0] rf_wdata_o;
  logic [DATA_W-1:0] pc_ckpt_i;
  logic              pc_we_o;
  logic [DATA_W-1:0] pc_o;
  logic              busy_o;
  logic              recovery_done_o;
`ifdef FT_RECOVERY_VERIFY_EN
  logic [DATA_W-1:0] rf_vdata_i;
  logic              verify_fail_o;
`endif

  modport slave (
    input  recover_i, recovering_i, rf_rdata_i, pc_ckpt_i,
`ifdef FT_RECOVERY_VERIFY_EN
    input  rf_vdata_i,
    output verify_fail_o,
`endif
    output rf_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o, pc_we_o, pc_o,
    output busy_o, recovery_done_o
  );

  modport master (
    output recover_i, recovering_i, rf_rdata_i, pc_ckpt_i,
`ifdef FT_RECOVERY_VERIFY_EN
    output rf_vdata_i,
    input  verify_fail_o,
`endif
    input  rf_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o, pc_we_o, pc_o,
    input  busy_o, recovery_done_o
  );

endinterface

// File: rtl/ft_recovery_unit_verify.sv
// Readback comparator and retry counter, present only with FT_RECOVERY_VERIFY_EN.
// retry_o asks the FSM to re-run COPY; exhausting retries leaves verify_fail_o sticky.
`ifdef FT_RECOVERY_VERIFY_EN
module ft_recovery_unit_verify
  import ft_recovery_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              cmp_en_i,
  input  logic              pass_end_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] vdata_i,
  output logic              retry_o,
  output logic              verify_fail_o
);

  localparam logic [1:0] LIMIT = 2'(RETRY_LIMIT);

  logic       mism_q, pulse_q, sticky_q;
  logic [1:0] tries_q;
  logic       mism_now, exhausted;

  assign mism_now  = mism_q | (cmp_en_i && (rdata_i != vdata_i));
  assign retry_o   = pass_end_i && mism_now && (tries_q < LIMIT);
  assign exhausted = pass_end_i && mism_now && (tries_q >= LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      mism_q   <= 1'b0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      tries_q  <= '0;
    end else begin
      mism_q   <= pass_end_i ? 1'b0 : mism_now;
      pulse_q  <= retry_o;
      sticky_q <= sticky_q | exhausted;
      tries_q  <= tries_q + 2'(retry_o);
    end
  end

  assign verify_fail_o = pulse_q | sticky_q;

endmodule
`endif

// File: rtl/ft_recovery_unit.sv
// Recovery responder: copies golden regfile + checkpoint PC into the target cores.
// Optional readback verification with retries is enabled by FT_RECOVERY_VERIFY_EN.
module ft_recovery_unit
  import ft_recovery_unit_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input logic              clk_i,
  input logic              rst_i,
  ft_recovery_unit_if.slave bus
);

`ifdef FT_RECOVERY_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  // One extra counter bit so the final index NUM_REGS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] R_END = (ADDR_W + 1)'(NUM_REGS);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   r_q, r_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] wa_q;
  logic              we_q, pcwe_q, done_q;
  logic              copying, pass_end, start, retry, wr_d;

  assign copying  = (state_q == COPY) || (state_q == VERIFY);
  assign pass_end = copying && pend_q && (r_q == R_END);
  assign start    = (state_q == IDLE) && bus.recover_i;

`ifdef FT_RECOVERY_VERIFY_EN
  ft_recovery_unit_verify #(.DATA_W(DATA_W)) u_verify (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (start),
    .cmp_en_i     ((state_q == VERIFY) && pend_q),
    .pass_end_i   ((state_q == VERIFY) && pass_end && bus.recovering_i),
    .rdata_i      (bus.rf_rdata_i),
    .vdata_i      (bus.rf_vdata_i),
    .retry_o      (retry),
    .verify_fail_o(bus.verify_fail_o)
  );
`else
  assign retry = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d = state_q;
    r_d     = r_q;
    pend_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COPY;
          r_d     = '0;
        end
      end
      COPY, VERIFY: begin
        if (!bus.recovering_i) begin
          state_d = IDLE;
        end else if (pass_end) begin
          r_d = '0;
          if (state_q == COPY) state_d = VERIFY_EN ? VERIFY : PC;
          else                 state_d = retry ? COPY : PC;
        end else begin
          r_d    = r_q + (ADDR_W + 1)'(1);
          pend_d = (r_q < R_END);
        end
      end
      PC:      state_d = bus.recovering_i ? DONE : IDLE;
      DONE:    if (!bus.recovering_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wr_d = pend_d && (state_d == COPY);

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values in parallel.
    if (rst_i) begin
      state_q <= IDLE;
      r_q     <= '0;
      pend_q  <= 1'b0;
      wa_q    <= '0;
      we_q    <= 1'b0;
      pcwe_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      pend_q  <= pend_d;
      wa_q    <= wr_d ? r_q[ADDR_W-1:0] : '0;
      we_q    <= wr_d;
      pcwe_q  <= (state_d == PC);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.rf_raddr_o      = (copying && (r_q < R_END)) ? r_q[ADDR_W-1:0] : '0;
  assign bus.rf_we_o         = we_q;
  assign bus.rf_waddr_o      = wa_q;
  assign bus.rf_wdata_o      = we_q ? bus.rf_rdata_i : '0;
  assign bus.pc_we_o         = pcwe_q;
  assign bus.pc_o            = pcwe_q ? bus.pc_ckpt_i : '0;
  assign bus.busy_o          = (state_q != IDLE);
  assign bus.recovery_done_o = done_q;

endmodule
